bfly_r2_pipe: RTL and testbench

Parametrised, fully pipelined radix-2 DIT butterfly for the 32-point FFT datapath and its larger successors. It computes out0 = in0 + in1·W and out1 = in0 − in1·W on signed fixed-point complex data. It adds three things over the fixed 32-bit butterfly:
- valid/ready flow control with global stall;
- per-beat inverse-transform and divide-by-2 scaling controls;
- a tag pass-through and an overflow flag.

It sits between the stage address generator and the stage result buffer.

---
 rtl/bfly_r2_pipe.sv | 152 +++++++++++++++
 tb/tb_bfly_r2_pipe.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bfly_r2_pipe.sv
// Three-stage radix-2 DIT butterfly with valid/ready flow control, IFFT conjugation and /2 scaling.
// Define BFLY_SAT_EN to clamp out-of-range results; otherwise they wrap to the low WIDTH bits.
module bfly_r2_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0_r,
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_r,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] tw_r,
  input  logic [WIDTH-1:0] tw_i,
  input  logic             inv,
  input  logic             scale,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0_r,
  output logic [WIDTH-1:0] out0_i,
  output logic [WIDTH-1:0] out1_r,
  output logic [WIDTH-1:0] out1_i,
  output logic [TAG_W-1:0] tag_out,
  output logic             ovf
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;
  localparam int TW = WIDTH + 1;
  localparam int OW = WIDTH + 2;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (FRAC - 1);

  logic w_en;
  assign in_ready = ~(out_valid & ~out_ready);
  assign w_en     = in_ready;

  logic                    r1_valid, r1_inv, r1_scale;
  logic signed [WIDTH-1:0] r1_a0r, r1_a0i, r1_ar, r1_ai, r1_wr, r1_wi;
  logic [TAG_W-1:0]        r1_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0;
      r1_inv   <= 1'b0;
      r1_scale <= 1'b0;
      r1_a0r   <= '0;
      r1_a0i   <= '0;
      r1_ar    <= '0;
      r1_ai    <= '0;
      r1_wr    <= '0;
      r1_wi    <= '0;
      r1_tag   <= '0;
    end else if (w_en) begin
      r1_valid <= in_valid;
      r1_inv   <= inv;
      r1_scale <= scale;
      r1_a0r   <= in0_r;
      r1_a0i   <= in0_i;
      r1_ar    <= in1_r;
      r1_ai    <= in1_i;
      r1_wr    <= tw_r;
      r1_wi    <= tw_i;
      r1_tag   <= tag_in;
    end
  end

  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;
  logic signed [SW-1:0] w_pr, w_pi;
  assign w_p_rr = PW'(r1_ar) * PW'(r1_wr);
  assign w_p_ii = PW'(r1_ai) * PW'(r1_wi);
  assign w_p_ri = PW'(r1_ar) * PW'(r1_wi);
  assign w_p_ir = PW'(r1_ai) * PW'(r1_wr);
  // inv conjugates the twiddle: (wr - j*wi) instead of (wr + j*wi)
  assign w_pr = r1_inv ? SW'(w_p_rr) + SW'(w_p_ii) : SW'(w_p_rr) - SW'(w_p_ii);
  assign w_pi = r1_inv ? SW'(w_p_ir) - SW'(w_p_ri) : SW'(w_p_ri) + SW'(w_p_ir);

  logic                    r2_valid, r2_scale;
  logic signed [WIDTH-1:0] r2_a0r, r2_a0i;
  logic signed [TW-1:0]    r2_tr, r2_ti;
  logic [TAG_W-1:0]        r2_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_valid <= 1'b0;
      r2_scale <= 1'b0;
      r2_a0r   <= '0;
      r2_a0i   <= '0;
      r2_tr    <= '0;
      r2_ti    <= '0;
      r2_tag   <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_scale <= r1_scale;
      r2_a0r   <= r1_a0r;
      r2_a0i   <= r1_a0i;
      r2_tr    <= TW'((w_pr + RND) >>> FRAC);
      r2_ti    <= TW'((w_pi + RND) >>> FRAC);
      r2_tag   <= r1_tag;
    end
  end

  // Lanes: 0 = out0_r, 1 = out0_i, 2 = out1_r, 3 = out1_i
  logic signed [OW-1:0] w_sum [4];
  logic signed [OW-1:0] w_scl [4];
  logic [WIDTH-1:0]     w_red [4];
  logic [3:0]           w_oor;

  assign w_sum[0] = OW'(r2_a0r) + OW'(r2_tr);
  assign w_sum[1] = OW'(r2_a0i) + OW'(r2_ti);
  assign w_sum[2] = OW'(r2_a0r) - OW'(r2_tr);
  assign w_sum[3] = OW'(r2_a0i) - OW'(r2_ti);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_scl[gi] = r2_scale ? (w_sum[gi] + OW'(1)) >>> 1 : w_sum[gi];
      // In range only when the top three bits are all equal
      assign w_oor[gi] = ~(&w_scl[gi][OW-1:WIDTH-1]) & (|w_scl[gi][OW-1:WIDTH-1]);
`ifdef BFLY_SAT_EN
      assign w_red[gi] = !w_oor[gi]        ? w_scl[gi][WIDTH-1:0] :
                         w_scl[gi][OW-1]   ? {1'b1, {(WIDTH-1){1'b0}}} :
                                             {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign w_red[gi] = w_scl[gi][WIDTH-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      out0_r    <= '0;
      out0_i    <= '0;
      out1_r    <= '0;
      out1_i    <= '0;
      tag_out   <= '0;
    end else if (w_en) begin
      out_valid <= r2_valid;
      ovf       <= r2_valid & (|w_oor);
      out0_r    <= w_red[0];
      out0_i    <= w_red[1];
      out1_r    <= w_red[2];
      out1_i    <= w_red[3];
      tag_out   <= r2_tag;
    end
  end

endmodule

// File: tb/tb_bfly_r2_pipe.sv
// Scoreboard bench for bfly_r2_pipe: directed test-plan beats plus randomized traffic with
// random back-pressure, checked against an exact-arithmetic model (BFLY_SAT_EN selects clamping).
module tb_bfly_r2_pipe;
  localparam int W = 32;
  localparam int F = 16;
  localparam logic signed [127:0] HALF = 128'sd1 <<< (F - 1);
  localparam logic signed [127:0] MAXV = (128'sd1 <<< (W - 1)) - 128'sd1;
  localparam logic signed [127:0] MINV = -(128'sd1 <<< (W - 1));

  typedef struct {
    logic [31:0] a0r, a0i, ar, ai, wr, wi;
    logic        inv, scale;
    logic [7:0]  tag;
  } beat_t;

  typedef struct {
    logic [31:0] o0r, o0i, o1r, o1i;
    logic [7:0]  tag;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk, rst, in_valid, in_ready, inv, scale, out_valid, out_ready, ovf;
  logic [31:0] in0_r, in0_i, in1_r, in1_i, tw_r, tw_i;
  logic [31:0] out0_r, out0_i, out1_r, out1_i;
  logic [7:0]  tag_in, tag_out;

  bfly_r2_pipe #(.WIDTH(W), .FRAC(F), .TAG_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in0_r(in0_r), .in0_i(in0_i), .in1_r(in1_r), .in1_i(in1_i),
    .tw_r(tw_r), .tw_i(tw_i), .inv(inv), .scale(scale), .tag_in(tag_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0_r(out0_r), .out0_i(out0_i), .out1_r(out1_r), .out1_i(out1_i),
    .tag_out(tag_out), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;
  logic drv_timeout = 1'b0;
  int   rdy_mode = 0;  // 0 = ready high, 1 = random, 2 = ready low

  // Exact reference: 128-bit arithmetic, only the documented truncation to WIDTH+1 bits on t
  function automatic logic signed [127:0] sx33(input logic signed [127:0] v);
    logic signed [32:0] t;
    t = v[32:0];
    return t;
  endfunction

  function automatic exp_t model(input beat_t b);
    exp_t e;
    logic signed [127:0] a0r, a0i, ar, ai, wr, wi, pr, pi, tr, ti;
    logic signed [127:0] s [4];
    logic [31:0] r [4];
    logic o;
    a0r = $signed(b.a0r); a0i = $signed(b.a0i);
    ar  = $signed(b.ar);  ai  = $signed(b.ai);
    wr  = $signed(b.wr);  wi  = $signed(b.wi);
    if (b.inv) begin
      pr = ar * wr + ai * wi;
      pi = ai * wr - ar * wi;
    end else begin
      pr = ar * wr - ai * wi;
      pi = ar * wi + ai * wr;
    end
    tr = sx33((pr + HALF) >>> F);
    ti = sx33((pi + HALF) >>> F);
    s[0] = a0r + tr; s[1] = a0i + ti; s[2] = a0r - tr; s[3] = a0i - ti;
    o = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (b.scale) s[k] = (s[k] + 1) >>> 1;
      if (s[k] > MAXV || s[k] < MINV) o = 1'b1;
`ifdef BFLY_SAT_EN
      if (s[k] > MAXV)      r[k] = 32'h7FFFFFFF;
      else if (s[k] < MINV) r[k] = 32'h80000000;
      else                  r[k] = s[k][31:0];
`else
      r[k] = s[k][31:0];
`endif
    end
    e.o0r = r[0]; e.o0i = r[1]; e.o1r = r[2]; e.o1i = r[3];
    e.tag = b.tag; e.ovf = o; e.cyc = 0;
    return e;
  endfunction

  function automatic beat_t mk(input logic [31:0] a0r, a0i, ar, ai, wr, wi,
                               input logic iv, sc, input logic [7:0] tg);
    beat_t b;
    b.a0r = a0r; b.a0i = a0i; b.ar = ar; b.ai = ai; b.wr = wr; b.wi = wi;
    b.inv = iv; b.scale = sc; b.tag = tg;
    return b;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] o0r, o0i, o1r, o1i,
                                  input logic [7:0] tg, input logic ov);
    exp_t e;
    e.o0r = o0r; e.o0i = o0i; e.o1r = o1r; e.o1i = o1i;
    e.tag = tg; e.ovf = ov; e.cyc = 0;
    return e;
  endfunction

  function automatic logic [31:0] rnd_d();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($signed($urandom) >>> 2);
  endfunction

  function automatic logic [31:0] rnd_w();
    logic [31:0] v;
    if ($urandom_range(0, 7) == 0) return $urandom;
    v = $urandom_range(0, 131072);
    return v - 32'h00010000;
  endfunction

  function automatic beat_t rnd_beat();
    return mk(rnd_d(), rnd_d(), rnd_d(), rnd_d(), rnd_w(), rnd_w(),
              1'($urandom), 1'($urandom), 8'($urandom));
  endfunction

  // Called aligned to posedge+1; pushes the expectation at the negedge preceding the accepting edge
  task automatic issue(input beat_t b, input exp_t e);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in0_r = b.a0r; in0_i = b.a0i; in1_r = b.ar; in1_i = b.ai;
    tw_r = b.wr; tw_i = b.wi; inv = b.inv; scale = b.scale; tag_in = b.tag;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.cyc = cyc;
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) drv_timeout = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       out_ready = ($urandom_range(0, 3) != 0);
        2:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: owns all counters; handles reset checks, scoreboard pops, stall stability and the summary
  initial begin : monitor
    exp_t        e;
    logic        prev_stall;
    logic [137:0] prev_outs, cur_outs;
    int          last_stall_cyc, lat;
    prev_stall = 1'b0;
    prev_outs = '0;
    last_stall_cyc = -1;
    forever begin
      @(negedge clk or posedge rst or posedge done);
      if (done) begin
        checks++;
        if (sb.size() != 0 || drv_timeout) begin
          errors++;
          $display("FAIL drain pending=%0d drv_timeout=%0b required pending=0 drv_timeout=0",
                   sb.size(), drv_timeout);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else if (rst) begin
        #1;
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b0) begin
          errors++;
          $display("FAIL rst_valid out_valid=%b ovf=%b required 0 0", out_valid, ovf);
        end
        checks++;
        if ({out0_r, out0_i, out1_r, out1_i, tag_out} !== '0) begin
          errors++;
          $display("FAIL rst_data o0=(%h,%h) o1=(%h,%h) tag=%h required all zero",
                   out0_r, out0_i, out1_r, out1_i, tag_out);
        end
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL rst_in_ready got %b required 1", in_ready);
        end
        sb.delete();
        prev_stall = 1'b0;
      end else begin
        cur_outs = {out0_r, out0_i, out1_r, out1_i, tag_out, ovf, out_valid};
        checks++;
        if (in_ready !== ~(out_valid & ~out_ready)) begin
          errors++;
          $display("FAIL in_ready got %b required %b", in_ready, ~(out_valid & ~out_ready));
        end
        if (prev_stall) begin
          checks++;
          if (cur_outs !== prev_outs) begin
            errors++;
            $display("FAIL stall_hold got %h required %h", cur_outs, prev_outs);
          end
        end
        if (out_valid && sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious out_valid=1 tag=%h required out_valid=0", tag_out);
        end else if (out_valid && out_ready) begin
          e = sb.pop_front();
          lat = cyc - e.cyc;
          checks++;
          if (out0_r !== e.o0r || out0_i !== e.o0i || out1_r !== e.o1r || out1_i !== e.o1i ||
              tag_out !== e.tag || ovf !== e.ovf) begin
            errors++;
            $display("FAIL beat got o0=(%h,%h) o1=(%h,%h) tag=%h ovf=%b required o0=(%h,%h) o1=(%h,%h) tag=%h ovf=%b",
                     out0_r, out0_i, out1_r, out1_i, tag_out, ovf,
                     e.o0r, e.o0i, e.o1r, e.o1i, e.tag, e.ovf);
          end else begin
            $display("beat tag=%h o0=(%h,%h) o1=(%h,%h) ovf=%b lat=%0d ok",
                     tag_out, out0_r, out0_i, out1_r, out1_i, ovf, lat);
          end
          checks++;
          if ((last_stall_cyc < e.cyc && lat != 3) || lat < 3) begin
            errors++;
            $display("FAIL latency tag=%h got %0d required %s3", e.tag, lat,
                     (last_stall_cyc < e.cyc) ? "" : ">=");
          end
        end
        if (out_valid && !out_ready) last_stall_cyc = cyc;
        prev_stall = out_valid & ~out_ready;
        prev_outs = cur_outs;
      end
    end
  end

  initial begin
    in_valid = 1'b0; inv = 1'b0; scale = 1'b0; tag_in = '0;
    in0_r = '0; in0_i = '0; in1_r = '0; in1_i = '0; tw_r = '0; tw_i = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Test-plan beats, back to back from the first edge after reset release
    issue(mk(32'h00010000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'hA1),
          mk_exp(32'h00020000, 0, 0, 0, 8'hA1, 1'b0));
    issue(mk(0, 0, 32'h00010000, 0, 0, 32'hFFFF0000, 1'b0, 1'b0, 8'hA2),
          mk_exp(0, 32'hFFFF0000, 0, 32'h00010000, 8'hA2, 1'b0));
    issue(mk(0, 0, 32'h00010000, 0, 0, 32'hFFFF0000, 1'b1, 1'b0, 8'hA3),
          mk_exp(0, 32'h00010000, 0, 32'hFFFF0000, 8'hA3, 1'b0));
    issue(mk(32'h00030000, 0, 32'h00010000, 0, 32'h00010000, 0, 1'b0, 1'b1, 8'hA4),
          mk_exp(32'h00020000, 0, 32'h00010000, 0, 8'hA4, 1'b0));
`ifdef BFLY_SAT_EN
    issue(mk(32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'hA5),
          mk_exp(32'h7FFFFFFF, 0, 0, 0, 8'hA5, 1'b1));
`else
    issue(mk(32'h7FFF0000, 0, 32'h7FFF0000, 0, 32'h00010000, 0, 1'b0, 1'b0, 8'hA5),
          mk_exp(32'hFFFE0000, 0, 0, 0, 8'hA5, 1'b1));
`endif
    drain();

    // Six tagged beats with out_ready dropped for two cycles mid-stream
    fork
      begin
        beat_t b;
        for (int t = 0; t < 6; t++) begin
          b = rnd_beat();
          b.tag = 8'(t);
          issue(b, model(b));
        end
      end
      begin
        repeat (4) @(negedge clk);
        rdy_mode = 2;
        repeat (2) @(negedge clk);
        rdy_mode = 0;
      end
    join
    drain();

    // Random traffic with input gaps and random back-pressure
    @(negedge clk);
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 300; n++) begin
      beat_t b;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      b = rnd_beat();
      issue(b, model(b));
    end
    @(negedge clk);
    rdy_mode = 0;
    drain();

    // Reset with three beats in flight, then a fresh beat after release
    for (int n = 0; n < 3; n++) begin
      beat_t b;
      b = rnd_beat();
      issue(b, model(b));
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    begin
      beat_t b;
      b = rnd_beat();
      issue(b, model(b));
    end
    drain();
    done = 1'b1;
  end
endmodule
